// File: rtl/plic_target_pkg.sv
`default_nettype none
// ============================================================================
// Module      : plic_target_pkg
// Description : Shared definitions for the PLIC hart target and its arbiter:
//               default widths, the "no interrupt" ID and the source-index
//               to interrupt-ID mapping.
// Revision    : 1.0 - initial release
// ============================================================================
package plic_target_pkg;

  localparam int PW_DEF    = 5;  // priority / threshold width
  localparam int IDW_DEF   = 4;  // interrupt ID width
  localparam int NO_IRQ_ID = 0;  // ID 0 is reserved for "nothing pending"

  // Source i (0-based) is reported to software as interrupt ID i+1.
  function automatic int src_to_id(input int idx);
    return idx + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/plic_target_if.sv
`default_nettype none
// ============================================================================
// Module      : plic_target_if
// Description : Claim/complete register interface between the hart (CSR/bus
//               side, master) and the PLIC target (slave).
//   claim_rd    : one-cycle strobe, hart reads the claim register
//   claim_id    : claim register value (registered in the target)
//   complete_wr : one-cycle strobe, hart writes the complete register
//   complete_id : ID being completed, qualified by complete_wr
// Revision    : 1.0 - initial release
// ============================================================================
interface plic_target_if
  import plic_target_pkg::*;
#(
  parameter int IDW = IDW_DEF
);

  logic           claim_rd;
  logic [IDW-1:0] claim_id;
  logic           complete_wr;
  logic [IDW-1:0] complete_id;

  modport master (
    output claim_rd,
    output complete_wr,
    output complete_id,
    input  claim_id
  );

  modport slave (
    input  claim_rd,
    input  complete_wr,
    input  complete_id,
    output claim_id
  );

endinterface
`default_nettype wire

// File: rtl/plic_prio_arb.sv
`default_nettype none
// ============================================================================
// Module      : plic_prio_arb
// Description : Combinational max-priority arbiter. Picks the eligible source
//               with the largest priority; ties resolve to the lowest index.
//               Stateless, so one instance can be shared per hart target.
//   elig_i     : per-source eligibility
//   prio_i     : packed priorities, source i at [i*PW +: PW]
//   win_id_o   : winning ID (index+1), or 0 when nothing is eligible
//   win_prio_o : priority of the winner, 0 when nothing is eligible
// Revision    : 1.0 - initial release
// ============================================================================
module plic_prio_arb
  import plic_target_pkg::*;
#(
  parameter int NSRC = 8,
  parameter int PW   = PW_DEF,
  parameter int IDW  = IDW_DEF
) (
  input  logic [NSRC-1:0]    elig_i,
  input  logic [NSRC*PW-1:0] prio_i,
  output logic [IDW-1:0]     win_id_o,
  output logic [PW-1:0]      win_prio_o
);

  logic [IDW-1:0] best_id;
  logic [PW-1:0]  best_prio;
  logic           found;

  // Ascending scan with a strict '>' keeps the earliest (lowest-index)
  // candidate on equal priority.
  always_comb begin
    best_id   = IDW'(NO_IRQ_ID);
    best_prio = '0;
    found     = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (elig_i[i] && (!found || (prio_i[i*PW +: PW] > best_prio))) begin
        found     = 1'b1;
        best_id   = IDW'(src_to_id(i));
        best_prio = prio_i[i*PW +: PW];
      end
    end
  end

  assign win_id_o   = best_id;
  assign win_prio_o = best_prio;

endmodule
`default_nettype wire

// File: rtl/plic_target.sv
`default_nettype none
// ============================================================================
// Module      : plic_target
// Description : Hart-side end of the interrupt controller. Arbitrates pending
//               sources against the hart threshold, drives the external
//               interrupt line and services claim/complete. A claimed source
//               gets a one-cycle ack so its gateway cell clears pending.
//   clk, rst      : clock, synchronous active-high reset
//   ip_i, en_i    : per-source pending / enable
//   prio_i        : packed priorities, source i at [i*PW +: PW]
//   thres_i       : hart priority threshold
//   bus           : claim/complete register interface (slave side)
//   ack_o         : one-cycle pulse to the claimed gateway cell
//   eip_o         : external interrupt request to the hart
//   in_service_o  : claimed-but-not-completed sources
// Revision    : 1.0 - initial release
// ============================================================================
module plic_target
  import plic_target_pkg::*;
#(
  parameter int NSRC = 8,
  parameter int PW   = PW_DEF,
  parameter int IDW  = IDW_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NSRC-1:0]    ip_i,
  input  logic [NSRC-1:0]    en_i,
  input  logic [NSRC*PW-1:0] prio_i,
  input  logic [PW-1:0]      thres_i,
  plic_target_if.slave       bus,
  output logic [NSRC-1:0]    ack_o,
  output logic               eip_o,
  output logic [NSRC-1:0]    in_service_o
);

  logic [IDW-1:0]  best_q, best_d;
  logic            eip_q, eip_d;
  logic [NSRC-1:0] in_service_q, in_service_d;
  logic [NSRC-1:0] ack_q, ack_d;

  logic [NSRC-1:0] elig;
  logic [NSRC-1:0] claim_hit;
  logic [NSRC-1:0] compl_hit;
  logic [IDW-1:0]  arb_id;
  logic [PW-1:0]   arb_prio;

  // Per-source decode. A source is held off while claimed and during its ack
  // cycle; claim decode uses the registered best_q, so claim_rd never reaches
  // claim_id combinationally. Out-of-range or zero complete IDs match nothing.
  for (genvar i = 0; i < NSRC; i++) begin : g_src
    assign elig[i] = ip_i[i] & en_i[i] & ~in_service_q[i] & ~ack_q[i]
                   & (prio_i[i*PW +: PW] > thres_i);
    assign claim_hit[i] = bus.claim_rd    & (best_q          == IDW'(src_to_id(i)));
    assign compl_hit[i] = bus.complete_wr & (bus.complete_id == IDW'(src_to_id(i)));
  end

  plic_prio_arb #(
    .NSRC (NSRC),
    .PW   (PW),
    .IDW  (IDW)
  ) u_arb (
    .elig_i     (elig),
    .prio_i     (prio_i),
    .win_id_o   (arb_id),
    .win_prio_o (arb_prio)
  );

  always_comb begin
    // The cycle of a claim read is a guard cycle: present nothing so a
    // back-to-back read cannot return the ID just claimed.
    best_d = bus.claim_rd ? IDW'(NO_IRQ_ID) : arb_id;
    // A winner always has priority above the threshold and "no winner"
    // reports priority 0, so this is exactly "arbitration result != 0".
    eip_d  = ~bus.claim_rd & (arb_prio > thres_i);
    // Claim and complete target different sources, so both may apply.
    in_service_d = (in_service_q & ~compl_hit) | claim_hit;
    ack_d        = claim_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      best_q       <= IDW'(NO_IRQ_ID);
      eip_q        <= 1'b0;
      in_service_q <= '0;
      ack_q        <= '0;
    end else begin
      best_q       <= best_d;
      eip_q        <= eip_d;
      in_service_q <= in_service_d;
      ack_q        <= ack_d;
    end
  end

  assign bus.claim_id = best_q;
  assign ack_o        = ack_q;
  assign eip_o        = eip_q;
  assign in_service_o = in_service_q;

endmodule
`default_nettype wire

// File: tb/tb_plic_target.sv
`default_nettype none
// ============================================================================
// Module      : tb_plic_target
// Description : Self-checking bench for plic_target: arbitration vector table,
//               model-checked random vectors, and hand-written claim/complete
//               and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_plic_target;

  localparam int NSRC = 8;
  localparam int PW   = 5;
  localparam int IDW  = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [NSRC-1:0]    ip, en, ack, insvc;
  logic [NSRC*PW-1:0] prio;
  logic [PW-1:0]      thres;
  logic               eip;

  int n_cmp  = 0;
  int n_fail = 0;

  plic_target_if #(.IDW(IDW)) bus ();

  plic_target #(.NSRC(NSRC), .PW(PW), .IDW(IDW)) dut (
    .clk          (clk),
    .rst          (rst),
    .ip_i         (ip),
    .en_i         (en),
    .prio_i       (prio),
    .thres_i      (thres),
    .bus          (bus),
    .ack_o        (ack),
    .eip_o        (eip),
    .in_service_o (insvc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  ip;
    logic [7:0]  en;
    logic [39:0] prio;
    logic [4:0]  thres;
    logic [3:0]  id;
    logic        eip;
  } vec_t;

  typedef struct {
    logic [3:0] id;
    logic       eip;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [39:0] pk(int p0, int p1, int p2, int p3,
                                     int p4, int p5, int p6, int p7);
    logic [39:0] r;
    r = {5'(p7), 5'(p6), 5'(p5), 5'(p4), 5'(p3), 5'(p2), 5'(p1), 5'(p0)};
    return r;
  endfunction

  // Reference arbitration with no sources in service.
  function automatic logic [3:0] model(logic [7:0] ipv, logic [7:0] env,
                                       logic [39:0] pv, logic [4:0] th);
    logic [3:0] id;
    logic [4:0] bp;
    id = 4'd0;
    bp = 5'd0;
    for (int i = 0; i < NSRC; i++) begin
      logic [4:0] p;
      p = pv[i*5 +: 5];
      if (ipv[i] && env[i] && p > th && (id == 4'd0 || p > bp)) begin
        id = 4'(i + 1);
        bp = p;
      end
    end
    return id;
  endfunction

  task automatic claim();
    bus.claim_rd = 1'b1;
    step();
    bus.claim_rd = 1'b0;
  endtask

  task automatic complete(input logic [3:0] id);
    bus.complete_wr = 1'b1;
    bus.complete_id = id;
    step();
    bus.complete_wr = 1'b0;
    bus.complete_id = 4'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    exp_t e;
    int   bad_ids[4];

    bus.claim_rd    = 1'b0;
    bus.complete_wr = 1'b0;
    bus.complete_id = 4'd0;

    // ---------------- reset ----------------
    rst = 1'b1; ip = 8'hFF; en = 8'hFF; thres = 5'd0;
    prio = pk(7, 7, 7, 7, 7, 7, 7, 7);
    for (int c = 0; c < 2; c++) begin
      step();
      chk("rst_id", 32'(bus.claim_id), 0);
      chk("rst_eip", 32'(eip), 0);
      chk("rst_ack", 32'(ack), 0);
      chk("rst_insvc", 32'(insvc), 0);
    end
    rst = 1'b0;
    step();
    chk("rel_id", 32'(bus.claim_id), 1);
    chk("rel_eip", 32'(eip), 1);

    // ---------------- vector table ----------------
    vecs[0] = '{8'hFF, 8'h00, pk(7,7,7,7,7,7,7,7), 5'd0, 4'd0, 1'b0};
    vecs[1] = '{8'h46, 8'hFF, pk(0,3,5,0,0,0,9,0), 5'd3, 4'd7, 1'b1};
    vecs[2] = '{8'h46, 8'hFF, pk(0,3,5,0,0,0,9,0), 5'd9, 4'd0, 1'b0};
    vecs[3] = '{8'h46, 8'hFF, pk(0,3,5,0,0,0,9,0), 5'd8, 4'd7, 1'b1};
    vecs[4] = '{8'h11, 8'hFF, pk(6,0,0,0,6,0,0,0), 5'd0, 4'd1, 1'b1};
    vecs[5] = '{8'h81, 8'hFF, pk(30,0,0,0,0,0,0,31), 5'd30, 4'd8, 1'b1};
    vecs[6] = '{8'hFF, 8'hFF, pk(0,0,0,0,0,0,0,0), 5'd0, 4'd0, 1'b0};
    vecs[7] = '{8'h0F, 8'h0A, pk(1,2,3,4,5,6,7,8), 5'd0, 4'd4, 1'b1};
    for (int v = 0; v < 8; v++) begin
      ip = vecs[v].ip; en = vecs[v].en; prio = vecs[v].prio; thres = vecs[v].thres;
      sb.push_back('{vecs[v].id, vecs[v].eip});
      step();
      e = sb.pop_front();
      chk($sformatf("vec%0d_id", v), 32'(bus.claim_id), 32'(e.id));
      chk($sformatf("vec%0d_eip", v), 32'(eip), 32'(e.eip));
    end

    // ---------------- random vectors vs model ----------------
    for (int r = 0; r < 16; r++) begin
      logic [3:0] mid;
      ip = 8'($urandom); en = 8'($urandom); thres = 5'($urandom_range(0, 31));
      for (int i = 0; i < NSRC; i++) prio[i*PW +: PW] = 5'($urandom);
      mid = model(ip, en, prio, thres);
      sb.push_back('{mid, mid != 4'd0});
      step();
      e = sb.pop_front();
      chk($sformatf("rnd%0d_id", r), 32'(bus.claim_id), 32'(e.id));
      chk($sformatf("rnd%0d_eip", r), 32'(eip), 32'(e.eip));
    end

    // ---------------- priority/threshold + handshake ----------------
    ip = 8'h46; en = 8'h46; thres = 5'd3; prio = pk(0, 3, 5, 0, 0, 0, 9, 0);
    step();
    chk("pt_id7", 32'(bus.claim_id), 7);
    chk("pt_eip", 32'(eip), 1);
    claim();
    chk("pt_ack40", 32'(ack), 32'h40);
    chk("pt_insvc40", 32'(insvc), 32'h40);
    chk("pt_guard_id", 32'(bus.claim_id), 0);
    chk("pt_guard_eip", 32'(eip), 0);
    ip[6] = 1'b0;  // gateway clears pending on ack
    step();
    chk("pt_ack_gone", 32'(ack), 0);
    chk("pt_id3", 32'(bus.claim_id), 3);
    complete(4'd7);
    chk("pt_cmp7_insvc", 32'(insvc), 0);
    chk("pt_after7_id", 32'(bus.claim_id), 3);
    claim();
    chk("hs_ack04", 32'(ack), 32'h04);
    chk("hs_insvc04", 32'(insvc), 32'h04);
    chk("hs_guard_id", 32'(bus.claim_id), 0);
    claim();  // back-to-back read sees 0 and changes nothing
    chk("hs_b2b_ack", 32'(ack), 0);
    chk("hs_b2b_insvc", 32'(insvc), 32'h04);
    chk("hs_b2b_id", 32'(bus.claim_id), 0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("hs_blocked_id", 32'(bus.claim_id), 0);
      chk("hs_blocked_eip", 32'(eip), 0);
    end
    complete(4'd3);
    chk("hs_cmp3_insvc", 32'(insvc), 0);
    chk("hs_cmp3_id_lag", 32'(bus.claim_id), 0);
    step();
    chk("hs_reelig_id", 32'(bus.claim_id), 3);
    chk("hs_reelig_eip", 32'(eip), 1);

    // ---------------- tie-break ----------------
    ip = 8'h11; en = 8'hFF; thres = 5'd0; prio = pk(6, 0, 0, 0, 6, 0, 0, 0);
    step();
    chk("tb_id1", 32'(bus.claim_id), 1);
    claim();
    chk("tb_ack01", 32'(ack), 32'h01);
    step();
    chk("tb_id5", 32'(bus.claim_id), 5);
    claim();
    chk("tb_insvc11", 32'(insvc), 32'h11);

    // ---------------- complete edge cases ----------------
    bad_ids = '{0, 9, 15, 3};
    foreach (bad_ids[k]) begin
      complete(4'(bad_ids[k]));
      chk($sformatf("cmp_ign%0d", bad_ids[k]), 32'(insvc), 32'h11);
    end

    // ---------------- reset mid-operation ----------------
    rst = 1'b1;
    step();
    chk("mr_insvc", 32'(insvc), 0);
    chk("mr_id", 32'(bus.claim_id), 0);
    chk("mr_eip", 32'(eip), 0);
    rst = 1'b0;
    step();
    chk("mr_re_id", 32'(bus.claim_id), 1);
    chk("mr_re_eip", 32'(eip), 1);

    // ---------------- simultaneous claim and complete ----------------
    claim();
    step();
    chk("sc_id5", 32'(bus.claim_id), 5);
    claim();
    chk("sc_insvc11", 32'(insvc), 32'h11);
    ip[1] = 1'b1; prio[1*PW +: PW] = 5'd4;
    step();
    chk("sc_id2", 32'(bus.claim_id), 2);
    bus.claim_rd = 1'b1;
    complete(4'd5);
    bus.claim_rd = 1'b0;
    chk("sc_insvc03", 32'(insvc), 32'h03);
    chk("sc_ack02", 32'(ack), 32'h02);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
